// File: rtl/mem_stage_pkg.sv
// Shared types and decode helpers for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      NONE, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD
   } mem_op_e;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

   function automatic logic is_load(mem_op_e op);
      return op inside {LB, LBU, LH, LHU, LW, LWU, LD};
   endfunction

   function automatic logic is_store(mem_op_e op);
      return op inside {SB, SH, SW, SD};
   endfunction

   // log2 of the access size in bytes
   function automatic logic [1:0] size_of(mem_op_e op);
      case (op)
         LH, LHU, SH:  return 2'd1;
         LW, LWU, SW:  return 2'd2;
         LD, SD:       return 2'd3;
         default:      return 2'd0;
      endcase
   endfunction

   // natural alignment check on the low address bits
   function automatic logic is_misaligned(mem_op_e op, logic [2:0] low);
      logic [2:0] mask;
      mask = 3'((4'd1 << size_of(op)) - 4'd1);
      return (is_load(op) | is_store(op)) && ((low & mask) != 3'd0);
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port: req/gnt request channel plus rvalid response channel.
interface mem_access_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned NB = DATA_W / 8;

   logic              mem_req;
   logic              mem_we;
   logic [NB-1:0]     mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load aligner: lane select by byte offset, then sign/zero extension.
module mem_load_align
   import mem_stage_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned NB     = DATA_W / 8,
   localparam int unsigned OFF_W  = $clog2(NB)
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [OFF_W-1:0]  offset,
   input  mem_op_e           op,
   output logic [DATA_W-1:0] result_c
);

   logic [DATA_W-1:0] shifted;

   // shift the addressed lane down to bit 0 and extend to the datapath width
   always_comb begin
      shifted  = rdata >> {offset, 3'b000};
      result_c = shifted;
      case (op)
         LB:      result_c = DATA_W'($signed(shifted[7:0]));
         LBU:     result_c = DATA_W'(shifted[7:0]);
         LH:      result_c = DATA_W'($signed(shifted[15:0]));
         LHU:     result_c = DATA_W'(shifted[15:0]);
         LW:      result_c = DATA_W'($signed(shifted[31:0]));
         LWU:     result_c = DATA_W'(shifted[31:0]);
         default: result_c = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX handshake in, data-memory req/gnt/rvalid port, registered WB output.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned SIDE_W  = 66
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [31:0]        ex_pc,
   input  mem_op_e            ex_mem_op,
   input  logic [ADDR_W-1:0]  ex_addr,
   input  logic [DATA_W-1:0]  ex_wdata,
   input  logic               ex_rf_we,
   input  logic [RADDR_W-1:0] ex_rf_waddr,
   input  logic [DATA_W-1:0]  ex_result,
   input  logic [SIDE_W-1:0]  ex_side,
   mem_access_stage_if.master mem,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [31:0]        wb_pc,
   output logic               wb_rf_we,
   output logic [RADDR_W-1:0] wb_rf_waddr,
   output logic [DATA_W-1:0]  wb_rf_wdata,
   output logic [SIDE_W-1:0]  wb_side,
   output logic               wb_excp_ade,
   output logic               stall_req
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(NB);

   state_e            state_q, state_d;
   mem_op_e           op_q;
   logic [OFF_W-1:0]  off_q;
   logic              mem_req_q, mem_we_q;
   logic [NB-1:0]     mem_be_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              accept_c, is_mem_c, misal_c, issue_c;
   logic [NB-1:0]     store_be_c;
   logic [DATA_W-1:0] store_data_c, load_data_c;

   assign ex_ready  = (state_q == IDLE) & (~wb_valid | wb_ready);
   assign stall_req = ex_valid & ~ex_ready;
   assign accept_c  = ex_valid & ex_ready & ~flush;
   assign is_mem_c  = is_load(ex_mem_op) | is_store(ex_mem_op);
   assign misal_c   = is_misaligned(ex_mem_op, ex_addr[2:0]);
   assign issue_c   = accept_c & is_mem_c & ~misal_c;

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

   // byte-enable mask at the address offset and low bytes replicated to every lane
   always_comb begin
      int unsigned nbytes;
      int unsigned off;
      nbytes = 32'(1) << size_of(ex_mem_op);
      if (nbytes > NB) nbytes = NB;
      off          = 32'(ex_addr[OFF_W-1:0]);
      store_be_c   = '0;
      store_data_c = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         store_be_c[i]           = (i >= off) && (i < off + nbytes);
         store_data_c[8*i +: 8]  = ex_wdata[8*(i & (nbytes - 1)) +: 8];
      end
   end

   mem_load_align #(.DATA_W(DATA_W)) u_load_align (
      .rdata    (mem.mem_rdata),
      .offset   (off_q),
      .op       (op_q),
      .result_c (load_data_c)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic; a grant coinciding with flush still owes us one rvalid for loads
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (issue_c) state_d = REQ;
         REQ: begin
            if (mem.mem_gnt) begin
               if (!is_load(op_q)) state_d = IDLE;
               else if (flush)     state_d = DRAIN;
               else                state_d = WAIT;
            end else if (flush) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (mem.mem_rvalid) state_d = IDLE;
            else if (flush)     state_d = DRAIN;
         end
         DRAIN: if (mem.mem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // memory request channel: loaded on issue, held until grant or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         op_q        <= NONE;
         off_q       <= '0;
      end else if (issue_c) begin
         mem_req_q   <= 1'b1;
         mem_we_q    <= is_store(ex_mem_op);
         mem_be_q    <= store_be_c;
         mem_addr_q  <= ex_addr & ~ADDR_W'(NB - 1);
         mem_wdata_q <= store_data_c;
         op_q        <= ex_mem_op;
         off_q       <= ex_addr[OFF_W-1:0];
      end else if (state_q == REQ && (mem.mem_gnt || flush)) begin
         mem_req_q   <= 1'b0;
      end
   end

   // WB output register; payload is captured on accept, valid raised on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid    <= 1'b0;
         wb_pc       <= '0;
         wb_rf_we    <= 1'b0;
         wb_rf_waddr <= '0;
         wb_rf_wdata <= '0;
         wb_side     <= '0;
         wb_excp_ade <= 1'b0;
      end else if (flush) begin
         wb_valid    <= 1'b0;
      end else if (accept_c) begin
         wb_valid    <= ~is_mem_c | misal_c;
         wb_pc       <= ex_pc;
         wb_rf_we    <= ex_rf_we & ~misal_c;
         wb_rf_waddr <= ex_rf_waddr;
         wb_rf_wdata <= ex_result;
         wb_side     <= ex_side;
         wb_excp_ade <= misal_c;
      end else if (state_q == REQ && mem.mem_gnt && !is_load(op_q)) begin
         wb_valid    <= 1'b1;
      end else if (state_q == WAIT && mem.mem_rvalid) begin
         wb_valid    <= 1'b1;
         wb_rf_wdata <= load_data_c;
      end else if (wb_ready) begin
         wb_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (DATA_W=32).
module tb_mem_access_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, flush, ex_valid, ex_ready, ex_rf_we;
   logic [31:0] ex_pc, ex_addr, ex_wdata, ex_result;
   mem_op_e     ex_mem_op;
   logic [4:0]  ex_rf_waddr, wb_rf_waddr;
   logic [65:0] ex_side, wb_side;
   logic        wb_valid, wb_ready, wb_rf_we, wb_excp_ade, stall_req;
   logic [31:0] wb_pc, wb_rf_wdata;

   int n_vec = 0;
   int n_err = 0;

   mem_access_stage_if #(.DATA_W(32), .ADDR_W(32)) mem_bus ();

   mem_access_stage #(.DATA_W(32), .ADDR_W(32), .RADDR_W(5), .SIDE_W(66)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_mem_op(ex_mem_op),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
      .ex_result(ex_result), .ex_side(ex_side), .mem(mem_bus),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
      .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata), .wb_side(wb_side),
      .wb_excp_ade(wb_excp_ade), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] res);
      ex_valid  = 1'b1;
      ex_mem_op = op;
      ex_addr   = addr;
      ex_wdata  = wd;
      ex_result = res;
      ex_rf_we  = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_pc = 32'h0; ex_mem_op = NONE;
      ex_addr = '0; ex_wdata = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0;
      ex_side = '0; wb_ready = 1'b1;
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
      tick(); tick();
      n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      n_vec++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b exp 0", mem_bus.mem_req); end
      n_vec++; if (wb_rf_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wb_rf_wdata got %h exp 0", wb_rf_wdata); end
      n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_none();
      present(NONE, 32'h0, 32'h0, 32'h1234_5678);
      ex_pc = 32'h0000_4000; ex_rf_waddr = 5'd7; ex_side = 66'h2_0000_0000_0000_0055;
      #1;
      n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL none_ex_ready got %b exp 1", ex_ready); end
      tick();
      ex_valid = 1'b0;
      n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL none_wb_valid got %b exp 1", wb_valid); end
      n_vec++; if (wb_rf_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL none_wdata got %h exp 12345678", wb_rf_wdata); end
      n_vec++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL none_mem_req got %b exp 0", mem_bus.mem_req); end
      n_vec++; if (wb_pc !== 32'h0000_4000 || wb_rf_waddr !== 5'd7 || wb_side !== 66'h2_0000_0000_0000_0055)
         begin n_err++; $display("FAIL none_payload got pc %h waddr %0d side %h", wb_pc, wb_rf_waddr, wb_side); end
      tick();
      n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL none_consumed got %b exp 0", wb_valid); end
   endtask

   // full load transaction with one-cycle grant and rvalid one cycle after grant
   task automatic run_load(input string name, input mem_op_e op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
      present(op, addr, 32'h0, 32'h0);
      tick();
      ex_valid = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== (addr & 32'hFFFF_FFFC))
         begin n_err++; $display("FAIL %s_req got req %b we %b addr %h", name, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr); end
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b0 || wb_valid !== 1'b0)
         begin n_err++; $display("FAIL %s_wait got req %b wb_valid %b exp 0 0", name, mem_bus.mem_req, wb_valid); end
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rdata;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      n_vec++; if (wb_valid !== 1'b1 || wb_rf_wdata !== exp)
         begin n_err++; $display("FAIL %s_data got valid %b data %h exp 1 %h", name, wb_valid, wb_rf_wdata, exp); end
      tick();
   endtask

   task automatic test_loads();
      run_load("lb",  LB,  32'h103, 32'h80AA_BBCC, 32'hFFFF_FF80);
      run_load("lbu", LBU, 32'h103, 32'h80AA_BBCC, 32'h0000_0080);
      run_load("lh",  LH,  32'h102, 32'h80AA_BBCC, 32'hFFFF_80AA);
      run_load("lhu", LHU, 32'h100, 32'h80AA_BBCC, 32'h0000_BBCC);
      run_load("lb1", LB,  32'h101, 32'h80AA_BBCC, 32'hFFFF_FFBB);
      run_load("lw",  LW,  32'h100, 32'h80AA_BBCC, 32'h80AA_BBCC);
   endtask

   task automatic test_store();
      present(SH, 32'h202, 32'h0000_BEEF, 32'h0);
      tick();
      ex_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1 || mem_bus.mem_be !== 4'b1100 ||
             mem_bus.mem_wdata !== 32'hBEEF_BEEF || mem_bus.mem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL sh_hold_c%0d got req %b we %b be %b wdata %h addr %h", c, mem_bus.mem_req,
                     mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_addr);
         end
         if (c == 3) mem_bus.mem_gnt = 1'b1;
         tick();
      end
      mem_bus.mem_gnt = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b0 || wb_valid !== 1'b1)
         begin n_err++; $display("FAIL sh_done got req %b wb_valid %b exp 0 1", mem_bus.mem_req, wb_valid); end
      tick();
      present(SB, 32'h201, 32'h0000_005A, 32'h0);
      tick();
      ex_valid = 1'b0;
      n_vec++; if (mem_bus.mem_be !== 4'b0010 || mem_bus.mem_wdata !== 32'h5A5A_5A5A)
         begin n_err++; $display("FAIL sb_lanes got be %b wdata %h exp 0010 5a5a5a5a", mem_bus.mem_be, mem_bus.mem_wdata); end
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0;
      tick();
   endtask

   task automatic test_misaligned();
      present(LW, 32'h101, 32'h0, 32'h0);
      tick();
      ex_valid = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL lw_mis_req got %b exp 0", mem_bus.mem_req); end
      n_vec++; if (wb_valid !== 1'b1 || wb_excp_ade !== 1'b1 || wb_rf_we !== 1'b0)
         begin n_err++; $display("FAIL lw_mis_wb got valid %b ade %b we %b exp 1 1 0", wb_valid, wb_excp_ade, wb_rf_we); end
      tick();
      present(SH, 32'h203, 32'h0, 32'h0);
      tick();
      ex_valid = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b0 || wb_excp_ade !== 1'b1 || wb_valid !== 1'b1)
         begin n_err++; $display("FAIL sh_mis got req %b ade %b valid %b exp 0 1 1", mem_bus.mem_req, wb_excp_ade, wb_valid); end
      tick();
      present(LH, 32'h102, 32'h0, 32'h0);
      tick();
      ex_valid = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b1 || wb_valid !== 1'b0)
         begin n_err++; $display("FAIL lh_aligned got req %b valid %b exp 1 0", mem_bus.mem_req, wb_valid); end
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h0;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      n_vec++; if (wb_excp_ade !== 1'b0 || wb_rf_we !== 1'b1)
         begin n_err++; $display("FAIL lh_no_ade got ade %b we %b exp 0 1", wb_excp_ade, wb_rf_we); end
      tick();
   endtask

   task automatic test_flush();
      // flush while waiting for load data
      present(LW, 32'h100, 32'h0, 32'h0);
      tick();
      ex_valid = 1'b0; mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL drain_ex_ready0 got %b exp 0", ex_ready); end
      tick();
      n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL drain_ex_ready1 got %b exp 0", ex_ready); end
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      n_vec++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1)
         begin n_err++; $display("FAIL drain_done got valid %b ready %b exp 0 1", wb_valid, ex_ready); end
      tick();
      n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL drain_discard got %b exp 0", wb_valid); end
      // flush in REQ with no grant drops the store
      present(SW, 32'h300, 32'h1, 32'h0);
      tick();
      ex_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1)
         begin n_err++; $display("FAIL req_flush got req %b valid %b ready %b exp 0 0 1", mem_bus.mem_req, wb_valid, ex_ready); end
      // grant coinciding with flush on a load still drains one rvalid
      present(LW, 32'h104, 32'h0, 32'h0);
      tick();
      ex_valid = 1'b0; flush = 1'b1; mem_bus.mem_gnt = 1'b1;
      tick();
      flush = 1'b0; mem_bus.mem_gnt = 1'b0;
      n_vec++; if (mem_bus.mem_req !== 1'b0 || ex_ready !== 1'b0)
         begin n_err++; $display("FAIL gnt_flush got req %b ready %b exp 0 0", mem_bus.mem_req, ex_ready); end
      mem_bus.mem_rvalid = 1'b1;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      n_vec++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1)
         begin n_err++; $display("FAIL gnt_flush_done got valid %b ready %b exp 0 1", wb_valid, ex_ready); end
      // flush beats a simultaneous accept
      present(NONE, 32'h0, 32'h0, 32'hCAFE_0001);
      flush = 1'b1;
      tick();
      flush = 1'b0; ex_valid = 1'b0;
      n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_priority got %b exp 0", wb_valid); end
      tick();
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b0;
      present(LW, 32'h100, 32'h0, 32'h0);
      tick();
      mem_bus.mem_gnt = 1'b1;
      present(LW, 32'h104, 32'h0, 32'h0);
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
      tick();
      mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h1111_2222 || stall_req !== 1'b1 ||
             ex_ready !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_hold_c%0d got valid %b data %h stall %b ready %b req %b", c, wb_valid,
                     wb_rf_wdata, stall_req, ex_ready, mem_bus.mem_req);
         end
         tick();
      end
      wb_ready = 1'b1;
      #1;
      n_vec++; if (ex_ready !== 1'b1 || stall_req !== 1'b0)
         begin n_err++; $display("FAIL b2b_release got ready %b stall %b exp 1 0", ex_ready, stall_req); end
      tick();
      ex_valid = 1'b0;
      n_vec++; if (wb_valid !== 1'b0 || mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h104)
         begin n_err++; $display("FAIL b2b_second got valid %b req %b addr %h exp 0 1 104", wb_valid, mem_bus.mem_req, mem_bus.mem_addr); end
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h3333_4444;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      n_vec++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h3333_4444)
         begin n_err++; $display("FAIL b2b_second_data got valid %b data %h exp 1 33334444", wb_valid, wb_rf_wdata); end
      tick();
   endtask

   initial begin
      test_reset();
      test_none();
      test_loads();
      test_store();
      test_misaligned();
      test_flush();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
